pc_sequencer: RTL and testbench

- Control FSM that sequences the ProgramCounter; drives its pc_write, pc_src and load_vector strobes, plus memory-address select and IR/operand load enables.
- Handles the reset-vector load from M[0], 1- and 2-byte fetch, branch/jump/RTI target loads, and interrupt entry via M[1].
- Sits between the instruction decoder/execute unit and the ProgramCounter/memory address mux.

---
 rtl/pc_sequencer.sv | 159 +++++++++++++++
 tb/tb_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/vector/interrupt control FSM driving the ProgramCounter.
// Optional macro SEQ_WATCHDOG_EN adds an EXEC watchdog (wdog_fault, reload from reset vector).
module pc_sequencer #(
  parameter logic [7:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR   = 8'h01,
  parameter int         WDOG_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       two_byte,
  input  logic       exec_done,
  input  logic       branch_taken,
  input  logic       rti,
  input  logic       halt,
  input  logic       irq,
  output logic       pc_write,
  output logic       pc_src,
  output logic       load_vector,
  output logic       addr_sel,
  output logic [7:0] vec_addr,
  output logic       ir_load,
  output logic       op2_load,
  output logic       int_ack,
  output logic       ie,
  output logic       wdog_fault
);

  typedef enum logic [2:0] {
    RST_VEC,
    FETCH,
    FETCH_OP2,
    EXEC,
    HALT,
    INT_SAVE,
    INT_VEC
  } state_t;

  state_t state, state_n;
  logic   ie_n;
  logic   irq_pend, pend_n;
  logic   take_int;
  logic   wd_exp;

`ifdef SEQ_WATCHDOG_EN
  logic [4:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (state != EXEC) begin
      wcnt <= '0;
    end else if (!exec_done) begin
      wcnt <= wcnt + 5'd1;
    end
  end

  assign wd_exp = (state == EXEC) && !exec_done &&
                  (wcnt == 5'(WDOG_CYCLES - 1));
`else
  assign wd_exp = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_VEC;
      ie       <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      state    <= state_n;
      ie       <= ie_n;
      irq_pend <= pend_n;
    end
  end

  // rti re-enables interrupts in the same cycle it retires
  assign take_int = irq_pend || (irq && (ie || rti));

  always_comb begin
    state_n     = state;
    ie_n        = ie;
    pend_n      = irq_pend;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    load_vector = 1'b0;
    addr_sel    = 1'b0;
    vec_addr    = '0;
    ir_load     = 1'b0;
    op2_load    = 1'b0;
    int_ack     = 1'b0;
    wdog_fault  = 1'b0;
    if (irq && ie) pend_n = 1'b1;
    unique case (state)
      RST_VEC: begin
        addr_sel    = 1'b1;
        vec_addr    = RESET_VEC_ADDR;
        load_vector = 1'b1;
        pc_write    = 1'b1;
        state_n     = FETCH;
      end
      FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_n  = two_byte ? FETCH_OP2 : EXEC;
      end
      FETCH_OP2: begin
        op2_load = 1'b1;
        pc_write = 1'b1;
        state_n  = EXEC;
      end
      EXEC: begin
        if (exec_done) begin
          if (branch_taken) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          if (rti) ie_n = 1'b1;
          if (take_int)  state_n = INT_SAVE;
          else if (halt) state_n = HALT;
          else           state_n = FETCH;
        end else if (wd_exp) begin
          wdog_fault = 1'b1;
          ie_n       = 1'b0;
          pend_n     = 1'b0;
          state_n    = RST_VEC;
        end
      end
      HALT: begin
        if (irq_pend) state_n = INT_SAVE;
      end
      INT_SAVE: begin
        int_ack = 1'b1;
        ie_n    = 1'b0;
        pend_n  = 1'b0;
        state_n = INT_VEC;
      end
      INT_VEC: begin
        addr_sel    = 1'b1;
        vec_addr    = INT_VEC_ADDR;
        load_vector = 1'b1;
        pc_write    = 1'b1;
        state_n     = FETCH;
      end
      default: state_n = RST_VEC;
    endcase
    // reset forces every output low even though the state is RST_VEC
    if (!rst_n) begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      load_vector = 1'b0;
      addr_sel    = 1'b0;
      vec_addr    = '0;
      ir_load     = 1'b0;
      op2_load    = 1'b0;
      int_ack     = 1'b0;
      wdog_fault  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random stimulus against a queue-of-cycles model.
// The bench keeps its own ProgramCounter driven by the DUT strobes.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       two_byte = 1'b0;
  logic       exec_done = 1'b0;
  logic       branch_taken = 1'b0;
  logic       rti = 1'b0;
  logic       halt = 1'b0;
  logic       irq = 1'b0;
  logic       pc_write, pc_src, load_vector, addr_sel;
  logic [7:0] vec_addr;
  logic       ir_load, op2_load, int_ack, ie, wdog_fault;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] pc_target = 8'h00;
  logic [7:0] pc_q = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .two_byte(two_byte),
    .exec_done(exec_done),
    .branch_taken(branch_taken),
    .rti(rti),
    .halt(halt),
    .irq(irq),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .load_vector(load_vector),
    .addr_sel(addr_sel),
    .vec_addr(vec_addr),
    .ir_load(ir_load),
    .op2_load(op2_load),
    .int_ack(int_ack),
    .ie(ie),
    .wdog_fault(wdog_fault)
  );

  localparam int K_VEC0  = 0;
  localparam int K_FETCH = 1;
  localparam int K_OP2   = 2;
  localparam int K_EXEC  = 3;
  localparam int K_HALT  = 4;
  localparam int K_SAVE  = 5;
  localparam int K_IVEC  = 6;
  localparam int WD      = 16;

  int         q[$];
  logic       m_ie, m_pend;
  logic [7:0] m_pc;
  int         m_ecyc;
  logic       saw_ack;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] outs();
    return {pc_write, pc_src, load_vector, addr_sel, vec_addr,
            ir_load, op2_load, int_ack, ie, wdog_fault};
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(K_VEC0);
    m_ie   = 1'b0;
    m_pend = 1'b0;
    m_pc   = 8'h00;
    m_ecyc = 0;
    pc_q   = 8'h00;
  endtask

  task automatic enter_isr();
    q.push_back(K_SAVE);
    q.push_back(K_IVEC);
    q.push_back(K_FETCH);
  endtask

  // one clock: drive at posedge+1, check at negedge, return at posedge+1
  task automatic step(input logic tb_, input logic ed, input logic bt,
                      input logic r, input logic h, input logic i,
                      input logic [7:0] md, input logic [7:0] pt);
    int cur;
    logic pw, ps, lv, as_, il, ol, ia, wd, intr;
    logic [7:0] va;
    two_byte = tb_; exec_done = ed; branch_taken = bt;
    rti = r; halt = h; irq = i; mem_data = md; pc_target = pt;
    @(negedge clk);
    cur = q.pop_front();
    {pw, ps, lv, as_, il, ol, ia, wd} = '0;
    va = 8'h00;
    intr = m_pend || (i && (m_ie || r));
    m_ecyc = (cur == K_EXEC) ? m_ecyc + 1 : 0;
`ifdef SEQ_WATCHDOG_EN
    wd = (cur == K_EXEC) && !ed && (m_ecyc == WD);
`endif
    case (cur)
      K_VEC0: begin
        pw = 1; lv = 1; as_ = 1; va = 8'h00; m_pc = md;
        q.push_back(K_FETCH);
      end
      K_FETCH: begin
        pw = 1; il = 1; m_pc = m_pc + 8'd1;
        if (tb_) q.push_back(K_OP2);
        q.push_back(K_EXEC);
      end
      K_OP2: begin
        pw = 1; ol = 1; m_pc = m_pc + 8'd1;
      end
      K_EXEC: begin
        if (ed) begin
          if (bt) begin pw = 1; ps = 1; m_pc = pt; end
          if (intr)   enter_isr();
          else if (h) q.push_back(K_HALT);
          else        q.push_back(K_FETCH);
        end else if (wd) begin
          q.push_back(K_VEC0);
        end else begin
          q.push_front(K_EXEC);
        end
      end
      K_HALT: begin
        if (m_pend) enter_isr();
        else q.push_front(K_HALT);
      end
      K_SAVE: ia = 1;
      K_IVEC: begin
        pw = 1; lv = 1; as_ = 1; va = 8'h01; m_pc = md;
      end
      default: ;
    endcase
    check($sformatf("outs[k%0d]", cur), outs(),
          {pw, ps, lv, as_, va, il, ol, ia, m_ie, wd});
    if (cur == K_SAVE) check("push_pc", pc_q, m_pc);
    saw_ack = int_ack;
    if (pc_write) begin
      if (load_vector) pc_q = mem_data;
      else if (pc_src) pc_q = pc_target;
      else pc_q = pc_q + 8'd1;
    end
    check("pc", pc_q, m_pc);
    if (cur == K_SAVE || wd) m_pend = 1'b0;
    else if (i && m_ie) m_pend = 1'b1;
    if (cur == K_SAVE || wd) m_ie = 1'b0;
    else if (cur == K_EXEC && ed && r) m_ie = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic i);
    step(0, 0, 0, 0, 0, i, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("rst_outs", outs(), 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("por_outs", outs(), 32'h0);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 0, 8'h10, 8'h00);
    check("vec_pc", pc_q, 8'h10);
    step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("fetch_pc", pc_q, 8'h11);
    step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    check("op2_pc", pc_q, 8'h12);
    repeat (3) idle(0);
    step(0, 1, 1, 0, 0, 0, 8'h00, 8'h50);
    check("branch_pc", pc_q, 8'h50);

    idle(0);
    step(0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
    check("rti_ie", ie, 1'b1);

    idle(0);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 8'h00, 8'h60);
    idle(0);
    check("save_ack", saw_ack, 1'b1);
    check("save_pc", pc_q, 8'h60);
    check("save_ie", ie, 1'b0);
    step(0, 0, 0, 0, 0, 0, 8'h80, 8'h00);
    check("ivec_pc", pc_q, 8'h80);

    idle(1);
    step(0, 1, 0, 0, 0, 1, 8'h00, 8'h00);
    check("masked_irq_ie", ie, 1'b0);
    idle(0);
    step(0, 1, 0, 1, 0, 0, 8'h00, 8'h00);
    check("rti_ie2", ie, 1'b1);

    idle(0);
    step(0, 1, 0, 0, 1, 0, 8'h00, 8'h00);
    repeat (10) idle(0);
    check("halt_ie", ie, 1'b1);
    begin
      logic got;
      got = 1'b0;
      for (int k = 0; k < 3 && !got; k++) begin
        idle(1);
        got = saw_ack;
      end
      check("halt_irq_ack", got, 1'b1);
    end
    idle(0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else if (n % 500 == 250) begin
        repeat (20) idle(1'($urandom_range(0, 9) == 0));
      end else begin
        step(1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) < 30),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 99) < 20),
             1'($urandom_range(0, 99) < 10),
             1'($urandom_range(0, 99) < 15),
             8'($urandom), 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
